axis_pkt_capture: RTL

Single-packet AXI-Stream capture and check stage: sits directly downstream of the AXIS packet generators and consumes one packet per arm request. Received bytes are assembled into a flat byte vector using the same layout the generator reads from, and the block reports byte length, first-beat user and framing errors. It also produces a registered match against an expected length and payload. Used by loopback and datapath benches, one instance per AXIS port.

---
 rtl/axis_pkt_pkg.sv | 28 ++
 rtl/axis_int.sv | 25 ++
 rtl/axis_pkt_capture.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared state type and tkeep helpers for the AXI-Stream packet capture stage.
// The helpers take a widened keep vector so one definition serves every DATA_BYTES.
package axis_pkt_pkg;

    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } axis_pkt_cap_state_t;

    // Nonzero and of the form 2^k-1, i.e. qualified bytes packed from lane 0 upward.
    function automatic logic keep_is_contiguous(input logic [KEEP_MAX-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX'(1))) == '0);
    endfunction

    function automatic logic [31:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + 32'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_int.sv
// Generic AXI-Stream bus with Master/Slave views, shared by generators and capture stages.
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
) (
    input logic clk,
    input logic sresetn
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tstrb;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport Master (input clk, sresetn, tready,
                    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest);
    modport Slave  (input clk, sresetn, tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                    output tready);
endinterface

// File: rtl/axis_pkt_capture.sv
// Captures one AXI-Stream packet per arm into a flat byte vector and checks it
// against a reference length/payload.
//   state | meaning
//   IDLE  | results held, waiting for arm
//   RECV  | tready high, bytes stored at beat*DATA_BYTES+lane
//   CHECK | one cycle, match registered from captured vs expected
//   DONE  | done pulse, results valid
module axis_pkt_capture
    import axis_pkt_pkg::*;
#(
    parameter int MTU_BYTES = 1500
) (
    input  logic                                  clk,
    input  logic                                  aresetn,
    AXIS_int.Slave                                axis_packet_in,
    input  logic                                  arm,
    output logic                                  busy,
    output logic                                  done,
    output logic [31:0]                           packet_byte_length,
    output logic [axis_packet_in.USER_WIDTH-1:0]  packet_user,
    output logic [MTU_BYTES*8-1:0]                packet_data,
    output logic                                  overflow,
    output logic                                  keep_error,
    input  logic [31:0]                           expected_byte_length,
    input  logic [MTU_BYTES*8-1:0]                expected_data,
    output logic                                  match
);
    localparam int          DATA_BYTES = axis_packet_in.DATA_BYTES;
    localparam int          BITW       = (MTU_BYTES * 8 > 1) ? $clog2(MTU_BYTES * 8) : 1;
    localparam logic [31:0] DB32       = 32'(DATA_BYTES);
    localparam logic [31:0] MTU32      = 32'(MTU_BYTES);

    axis_pkt_cap_state_t state_q, state_n;
    logic                tready_q;
    logic [31:0]         beat_cnt;
    logic                beat_acc;
    logic                keep_bad;
    logic                data_ok;
    logic [31:0]         lane_idx [DATA_BYTES];
    logic [BITW-1:0]     lane_bit [DATA_BYTES];
    logic                lane_ok  [DATA_BYTES];

    // Sideband fields this stage does not interpret.
    logic unused_ok;
    assign unused_ok = ^{axis_packet_in.clk, axis_packet_in.sresetn, axis_packet_in.tstrb,
                         axis_packet_in.tid, axis_packet_in.tdest};

    assign axis_packet_in.tready = tready_q;
    assign beat_acc = axis_packet_in.tvalid & tready_q;
    assign keep_bad = axis_packet_in.tlast
                    ? !keep_is_contiguous(KEEP_MAX'(axis_packet_in.tkeep))
                    : (axis_packet_in.tkeep != '1);

    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (arm) state_n = RECV;
            RECV: begin
                busy = 1'b1;
                if (beat_acc && axis_packet_in.tlast) state_n = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            tready_q <= (state_n == RECV);
        end
    end

    always_comb begin
        for (int b = 0; b < DATA_BYTES; b++) begin
            lane_idx[b] = beat_cnt * DB32 + 32'(b);
            lane_ok[b]  = lane_idx[b] < MTU32;
            lane_bit[b] = BITW'(lane_idx[b] * 32'd8);
        end
    end

    // Bytes beyond the expected length (capped at the MTU) are don't-care.
    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < MTU_BYTES; i++) begin
            if ((32'(i) < expected_byte_length) &&
                (packet_data[8*i +: 8] != expected_data[8*i +: 8])) begin
                data_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            packet_data        <= '0;
            packet_byte_length <= '0;
            packet_user        <= '0;
            overflow           <= 1'b0;
            keep_error         <= 1'b0;
            match              <= 1'b0;
            beat_cnt           <= '0;
        end else begin
            if (state_q == IDLE && arm) begin
                packet_data        <= '0;
                packet_byte_length <= '0;
                packet_user        <= '0;
                overflow           <= 1'b0;
                keep_error         <= 1'b0;
                match              <= 1'b0;
                beat_cnt           <= '0;
            end else if (beat_acc) begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (axis_packet_in.tkeep[b]) begin
                        if (lane_ok[b]) packet_data[lane_bit[b] +: 8] <= axis_packet_in.tdata[8*b +: 8];
                        else            overflow <= 1'b1;
                    end
                end
                packet_byte_length <= packet_byte_length + popcount(KEEP_MAX'(axis_packet_in.tkeep));
                if (beat_cnt == '0) packet_user <= axis_packet_in.tuser;
                if (keep_bad)       keep_error  <= 1'b1;
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (state_q == CHECK) begin
                match <= (packet_byte_length == expected_byte_length) &&
                         !overflow && !keep_error && data_ok;
            end
        end
    end

endmodule
